// File: rtl/rgb565_crop_packer_if.sv
// Pixel-stream input and frame-buffer FIFO output of the RGB565 crop/packer.
// The bench drives through the master modport and the packer uses the slave modport.
interface rgb565_crop_packer_if;
    logic        vs_i;
    logic        de_i;
    logic        pix_vld_i;
    logic [15:0] pdata_i;
    logic        wr_full_i;
    logic        wr_en_o;
    logic [63:0] wr_data_o;
    logic        frame_start_o;
    logic        frame_done_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    modport master (
        output vs_i, de_i, pix_vld_i, pdata_i, wr_full_i,
        input  wr_en_o, wr_data_o, frame_start_o, frame_done_o, overflow_o, drop_cnt_o
    );

    modport slave (
        input  vs_i, de_i, pix_vld_i, pdata_i, wr_full_i,
        output wr_en_o, wr_data_o, frame_start_o, frame_done_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/rgb565_crop_packer.sv
// Crops a fixed window out of the camera RGB565 stream and packs 4 kept pixels per
// 64-bit FIFO word, reporting frame start/done and dropped words on a full FIFO.
module rgb565_crop_packer #(
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int OUT_W   = 1280,
    parameter int OUT_H   = 720,
    parameter int CNT_W   = 12
) (
    input  logic                 pclk,
    input  logic                 rst,
    rgb565_crop_packer_if.slave  bus
);
    localparam logic [CNT_W-1:0] X_S    = CNT_W'(X_START);
    localparam logic [CNT_W-1:0] Y_S    = CNT_W'(Y_START);
    localparam logic [CNT_W-1:0] WIN_W  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] WIN_H  = CNT_W'(OUT_H);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_START + OUT_W - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_START + OUT_H - 1);

    typedef enum logic [1:0] {WAIT_VS, FRAME, DONE} state_t;

    state_t            state_reg;
    logic              vs_d_reg;
    logic              de_d_reg;
    logic              line_hit_reg;
    logic [CNT_W-1:0]  x_reg;
    logic [CNT_W-1:0]  y_reg;
    logic [1:0]        slot_reg;
    logic [15:0]       lane_reg [3];
    logic              wr_en_reg;
    logic [63:0]       wr_data_reg;
    logic              frame_start_reg;
    logic              frame_done_reg;
    logic              overflow_reg;
    logic [15:0]       drop_cnt_reg;

    logic              vs_rise;
    logic              de_fall;
    logic [CNT_W-1:0]  x_off;
    logic [CNT_W-1:0]  y_off;
    logic              keep;
    logic              last_pix;
    logic              lane_we;
    logic [63:0]       full_word;

    assign vs_rise  = bus.vs_i & ~vs_d_reg;
    assign de_fall  = ~bus.de_i & de_d_reg;
    // Offsets below the window start wrap to large values, so one compare per axis suffices.
    assign x_off    = x_reg - X_S;
    assign y_off    = y_reg - Y_S;
    assign keep     = (x_off < WIN_W) && (y_off < WIN_H);
    assign last_pix = (x_reg == X_LAST) && (y_reg == Y_LAST);
    assign lane_we  = (state_reg == FRAME) && !vs_rise && bus.pix_vld_i && keep;
    assign full_word = {bus.pdata_i, lane_reg[2], lane_reg[1], lane_reg[0]};

    // Slots 0..2 are buffered; slot 3 comes straight from the input in the completing cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge pclk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (lane_we && slot_reg == 2'(gi)) begin
                    lane_reg[gi] <= bus.pdata_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg       <= WAIT_VS;
            vs_d_reg        <= 1'b0;
            de_d_reg        <= 1'b0;
            line_hit_reg    <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            slot_reg        <= '0;
            wr_en_reg       <= 1'b0;
            wr_data_reg     <= '0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
            drop_cnt_reg    <= '0;
        end else begin
            vs_d_reg        <= bus.vs_i;
            de_d_reg        <= bus.de_i;
            wr_en_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            if (vs_rise) begin
                state_reg       <= FRAME;
                frame_start_reg <= 1'b1;
                x_reg           <= '0;
                y_reg           <= '0;
                slot_reg        <= '0;
                line_hit_reg    <= 1'b0;
                overflow_reg    <= 1'b0;
                drop_cnt_reg    <= '0;
            end else if (state_reg == FRAME) begin
                if (bus.pix_vld_i) begin
                    x_reg        <= x_reg + CNT_W'(1);
                    line_hit_reg <= 1'b1;
                    if (keep) begin
                        slot_reg <= slot_reg + 2'd1;
                        if (slot_reg == 2'd3) begin
                            if (!bus.wr_full_i) begin
                                wr_en_reg   <= 1'b1;
                                wr_data_reg <= full_word;
                            end else begin
                                overflow_reg <= 1'b1;
                                if (drop_cnt_reg != 16'hFFFF) begin
                                    drop_cnt_reg <= drop_cnt_reg + 16'd1;
                                end
                            end
                        end
                        if (last_pix) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= DONE;
                        end
                    end
                end
                // Lines without any strobe do not advance y; short lines lose their partial word.
                if (de_fall) begin
                    x_reg        <= '0;
                    slot_reg     <= '0;
                    line_hit_reg <= 1'b0;
                    if (line_hit_reg || bus.pix_vld_i) begin
                        y_reg <= y_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.wr_en_o       = wr_en_reg;
    assign bus.wr_data_o     = wr_data_reg;
    assign bus.frame_start_o = frame_start_reg;
    assign bus.frame_done_o  = frame_done_reg;
    assign bus.overflow_o    = overflow_reg;
    assign bus.drop_cnt_o    = drop_cnt_reg;
endmodule

// File: doc/rgb565_crop_packer.md
Name: rgb565_crop_packer

Overview:
Downstream neighbour of the OV5640 8-to-16-bit converter, running in the camera pclk domain. Takes the registered RGB565 pixel stream (pixel strobe, line enable, vsync) and tracks pixel X/Y within each frame. Crops a fixed window, packs 4 consecutive cropped pixels into one 64-bit word, and pushes words into the frame-buffer write FIFO. Flags overflow and frame boundaries for the DDR write controller.

Parameters:
X_START, 0, first kept column (pixel index within line, 0-based)
Y_START, 0, first kept line (line index within frame, 0-based)
OUT_W, 1280, kept pixels per line; must be a nonzero multiple of 4
OUT_H, 720, kept lines per frame; nonzero
CNT_W, 12, width of X/Y counters; must hold X_START+OUT_W and Y_START+OUT_H

Ports:
pclk  in  1  camera pixel clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
vs_i  in  1  vsync, active-high; rising edge = new frame
de_i  in  1  line enable (registered copy from converter)
pix_vld_i  in  1  one-cycle strobe, pdata_i holds a pixel
pdata_i  in  16  RGB565 pixel
wr_full_i  in  1  write FIFO full
wr_en_o  out  1  one-cycle FIFO write strobe
wr_data_o  out  64  packed word; pixel 0 in [15:0], pixel 3 in [63:48]
frame_start_o  out  1  one-cycle pulse on vsync rising edge
frame_done_o  out  1  one-cycle pulse with wr_en_o of last word of window
overflow_o  out  1  sticky: a word was dropped this frame
drop_cnt_o  out  16  dropped words this frame, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at a pclk edge): all outputs 0, x=y=0, pack slot=0, vs_d=0, de_d=0, state=WAIT_VS.
- Edge detection: vs_d, de_d registered each cycle. vs_rise = vs_i & ~vs_d. de_fall = ~de_i & de_d.
- States:
  - WAIT_VS: ignore pixels until vs_rise, then go to FRAME.
  - FRAME: process pixels.
  - DONE: window complete; ignore pixels until next vs_rise.
- vs_rise in any state:
  - frame_start_o=1 next cycle; x=y=0, slot=0, partial word discarded.
  - overflow_o and drop_cnt_o cleared; state=FRAME.
  - A pix_vld_i in the same cycle is discarded (vs_rise has priority).
- In FRAME, on pix_vld_i:
  - Keep if X_START <= x < X_START+OUT_W and Y_START <= y < Y_START+OUT_H.
  - x increments on every pixel, kept or not; no wrap needed within a line.
- Kept pixel is stored in slot s (bits 16s+15:16s); slot increments mod 4.
- On the 4th kept pixel (slot 3), the word is complete in that cycle; outputs follow one cycle later (latency 1 cycle from the 4th pix_vld_i):
  - if wr_full_i=0 in the completing cycle: wr_en_o=1 and wr_data_o=word.
  - else: wr_en_o=0, overflow_o=1, drop_cnt_o+1 (saturating); the word is lost, packing continues.
- wr_data_o holds its last value when wr_en_o=0.
- de_fall in FRAME: x=0, slot=0, y increments only if at least one pixel arrived on that line. Since OUT_W is a multiple of 4, slot is already 0 for well-formed lines; a short line discards its partial word.
- frame_done_o: pulses in the cycle the final word of the window is due (last kept pixel of line Y_START+OUT_H-1), whether that word is written or dropped. State then goes to DONE.
- Frame longer than window: extra lines/pixels ignored. Frame shorter: no frame_done_o; the next vs_rise restarts cleanly.
- rst asserted mid-frame: immediate return to reset values at that edge; no wr_en_o after.
- Throughput: accepts pix_vld_i on consecutive cycles (no back-to-back restriction).

Test Plan:
- Params X_START=2, Y_START=1, OUT_W=8, OUT_H=2. Drive vs pulse, then 3 lines of 12 pixels, pixel value = {y[7:0], x[7:0]}, pix_vld every 2nd cycle. Required response:
  - frame_start_o: one pulse.
  - Exactly 4 wr_en_o.
  - First word 64'h0105_0104_0103_0102; last word 64'h0209_0208_0207_0206.
  - frame_done_o coincides with 4th wr_en_o.
- Same stream with wr_full_i=1 during the 2nd word: 3 writes; overflow_o=1; drop_cnt_o=1; frame_done_o still pulses.
- Next vs_rise after the overflow frame: overflow_o=0 and drop_cnt_o=0 one cycle after the edge.
- vs_rise mid-line after 2 kept pixels, coincident with a pix_vld: no wr_en_o for the partial word. Next frame's first word starts at x=2, y=1.
- Line with no pix_vld (de high, no strobes): y unchanged. Pixels before first vs_rise after reset: no wr_en_o.
- rst=1 for one cycle mid-frame after 3 kept pixels: all outputs 0; no writes until vs_rise; then normal packing from slot 0.
